hls_loop_sequencer: RTL and testbench

- Sequences a Vivado-HLS-generated engine core (ap_start/ap_ready/ap_done/ap_idle protocol) over a two-level loop nest (outer K, inner L), one HLS invocation per (k,l) point.
- Sits between the HWPE controller FSM (start/clear, flags) and the HLS datapath.
- Exports the current (k,l) indices so streamers and address generators can follow issue order.
- Bounds the number of in-flight HLS invocations.

---
 rtl/hls_seq_pkg.sv | 29 ++
 rtl/hls_loop_idx_cnt.sv | 41 ++++
 rtl/hls_loop_sequencer.sv | 156 +++++++++++++++
 tb/tb_hls_loop_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hls_seq_pkg.sv
// Shared types and constants for the HLS loop sequencer and its index counter.
package hls_seq_pkg;

    localparam int SEQ_CNT_W = 16;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_ISSUE,
        SEQ_DRAIN,
        SEQ_FIN
    } seq_state_t;

    typedef struct packed {
        logic                 start;
        logic                 clear;
        logic [SEQ_CNT_W-1:0] max_lk;
        logic [SEQ_CNT_W-1:0] max_ll;
    } ctrl_seq_t;

    typedef struct packed {
        logic                 busy;
        logic                 done;
        logic                 idle;
        logic                 err;
        logic [SEQ_CNT_W-1:0] idx_k;
        logic [SEQ_CNT_W-1:0] idx_l;
    } flags_seq_t;

endpackage

// File: rtl/hls_loop_idx_cnt.sv
// Two-level wrapping (k,l) index counter; holds on the last point of the nest.
module hls_loop_idx_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] max_k,
    input  logic [CNT_W-1:0] max_l,
    output logic [CNT_W-1:0] idx_k,
    output logic [CNT_W-1:0] idx_l,
    output logic             last
);

    logic last_k;
    logic last_l;

    assign last_k = (idx_k == max_k - CNT_W'(1));
    assign last_l = (idx_l == max_l - CNT_W'(1));
    assign last   = last_k && last_l;

    // The final point is kept visible until the next clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_k <= '0;
            idx_l <= '0;
        end else if (clr) begin
            idx_k <= '0;
            idx_l <= '0;
        end else if (en && !last) begin
            if (last_l) begin
                idx_l <= '0;
                idx_k <= idx_k + CNT_W'(1);
            end else begin
                idx_l <= idx_l + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/hls_loop_sequencer.sv
// Drives an ap_ctrl_hs HLS core once per (k,l) point of a two-level loop nest,
// bounding the number of accepted-but-unfinished invocations.
module hls_loop_sequencer
    import hls_seq_pkg::*;
#(
    parameter int CNT_W     = SEQ_CNT_W,
    parameter int MAX_OUTST = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic [CNT_W-1:0] max_lk_i,
    input  logic [CNT_W-1:0] max_ll_i,
    output logic             ap_start_o,
    input  logic             ap_ready_i,
    input  logic             ap_done_i,
    input  logic             ap_idle_i,
    output logic [CNT_W-1:0] idx_k_o,
    output logic [CNT_W-1:0] idx_l_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             idle_o,
    output logic             err_o
);

    localparam logic [3:0] MAX_OUTST_C = 4'(MAX_OUTST);

    seq_state_t         state_q;
    seq_state_t         state_d;
    logic [CNT_W-1:0]   lk_q;
    logic [CNT_W-1:0]   ll_q;
    logic [3:0]         outst_q;
    logic [3:0]         outst_d;
    logic [2*CNT_W-1:0] compl_q;
    logic [2*CNT_W-1:0] compl_d;
    logic [2*CNT_W-1:0] total;
    logic               err_q;
    logic               can_start;
    logic               issue;
    logic               done_ok;
    logic               start_acc;
    logic               zero_bound;
    logic               cnt_clr;
    logic               cnt_last;

    assign start_acc  = (state_q == SEQ_IDLE) && start_i;
    assign zero_bound = (max_lk_i == '0) || (max_ll_i == '0);
    assign can_start  = (state_q == SEQ_ISSUE) && (outst_q < MAX_OUTST_C);
    assign issue      = can_start && ap_ready_i;
    assign done_ok    = ap_done_i && (outst_q != 4'd0);
    assign cnt_clr    = clear_i || start_acc;
    assign total      = {{CNT_W{1'b0}}, lk_q} * {{CNT_W{1'b0}}, ll_q};
    assign compl_d    = compl_q + {{(2*CNT_W-1){1'b0}}, done_ok};
    assign idle_o     = (state_q == SEQ_IDLE) && ap_idle_i;
    assign err_o      = err_q;

    // A simultaneous issue and completion leaves the in-flight count unchanged.
    always_comb begin
        outst_d = outst_q;
        if (issue && !done_ok) begin
            outst_d = outst_q + 4'd1;
        end else if (done_ok && !issue) begin
            outst_d = outst_q - 4'd1;
        end
    end

    hls_loop_idx_cnt #(
        .CNT_W(CNT_W)
    ) u_idx_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (cnt_clr),
        .en    (issue),
        .max_k (lk_q),
        .max_l (ll_q),
        .idx_k (idx_k_o),
        .idx_l (idx_l_o),
        .last  (cnt_last)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= SEQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DRAIN looks at the post-update counts so done_o follows the last ap_done by one cycle.
    always_comb begin
        state_d    = state_q;
        ap_start_o = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                if (start_i) begin
                    state_d = zero_bound ? SEQ_FIN : SEQ_ISSUE;
                end
            end
            SEQ_ISSUE: begin
                busy_o     = 1'b1;
                ap_start_o = can_start;
                if (issue && cnt_last) begin
                    state_d = SEQ_DRAIN;
                end
            end
            SEQ_DRAIN: begin
                busy_o = 1'b1;
                if ((outst_d == 4'd0) && (compl_d == total)) begin
                    state_d = SEQ_FIN;
                end
            end
            SEQ_FIN: begin
                done_o  = 1'b1;
                state_d = SEQ_IDLE;
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
        if (clear_i) begin
            state_d = SEQ_IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lk_q    <= '0;
            ll_q    <= '0;
            outst_q <= 4'd0;
            compl_q <= '0;
            err_q   <= 1'b0;
        end else if (clear_i) begin
            lk_q    <= '0;
            ll_q    <= '0;
            outst_q <= 4'd0;
            compl_q <= '0;
            err_q   <= 1'b0;
        end else begin
            outst_q <= outst_d;
            if (ap_done_i && (outst_q == 4'd0)) begin
                err_q <= 1'b1;
            end
            if (start_acc) begin
                lk_q    <= max_lk_i;
                ll_q    <= max_ll_i;
                compl_q <= '0;
            end else begin
                compl_q <= compl_d;
            end
        end
    end

endmodule

// File: tb/tb_hls_loop_sequencer.sv
// Bench for hls_loop_sequencer: an HLS core model answers ap_start, and a scoreboard
// of expected (k,l) points is checked at every issue handshake.
module tb_hls_loop_sequencer;

    localparam int CNT_W = 16;
    localparam int MAXO  = 2;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic             clear_i;
    logic [CNT_W-1:0] max_lk_i;
    logic [CNT_W-1:0] max_ll_i;
    logic             ap_start_o;
    logic             ap_ready_i;
    logic             ap_done_i;
    logic             ap_idle_i;
    logic [CNT_W-1:0] idx_k_o;
    logic [CNT_W-1:0] idx_l_o;
    logic             busy_o;
    logic             done_o;
    logic             idle_o;
    logic             err_o;

    bit          model_en;
    bit          pipe_mode;
    logic        inj_done;
    int          lat;
    int          pend[$];
    logic [31:0] exp_q[$];
    int          cyc;
    int          issue_cnt;
    int          start_seen;
    int          done_seen;
    int          done_cyc;
    int          last_done_cyc;
    int          start_cyc;
    int          total_cnt;
    int          bad_cnt;

    hls_loop_sequencer #(
        .CNT_W     (CNT_W),
        .MAX_OUTST (MAXO)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .clear_i    (clear_i),
        .max_lk_i   (max_lk_i),
        .max_ll_i   (max_ll_i),
        .ap_start_o (ap_start_o),
        .ap_ready_i (ap_ready_i),
        .ap_done_i  (ap_done_i),
        .ap_idle_i  (ap_idle_i),
        .idx_k_o    (idx_k_o),
        .idx_l_o    (idx_l_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .idle_o     (idle_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock cycle: HLS model and scoreboard act at the falling edge, then step past the rising edge.
    task automatic tick();
        int          inflight;
        logic [31:0] e;
        @(negedge clk);
        inflight = pend.size();
        if (busy_o && inflight >= MAXO) begin
            checkOutput("outst_limit", 32'(ap_start_o), 0);
        end
        ap_done_i = inj_done;
        if (model_en && pend.size() > 0) begin
            if (pend[0] == cyc) begin
                ap_done_i = 1'b1;
                void'(pend.pop_front());
                last_done_cyc = cyc;
            end
        end
        ap_ready_i = model_en && ap_start_o && (pipe_mode || pend.size() == 0);
        if (ap_start_o) start_seen++;
        if (ap_start_o && ap_ready_i) begin
            issue_cnt++;
            pend.push_back(cyc + lat);
            if (exp_q.size() == 0) begin
                checkOutput("extra_issue", 1, 0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("issue_idx", {idx_k_o, idx_l_o}, e);
            end
        end
        if (done_o) begin
            done_seen++;
            done_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic applyStimulus(input int lk, input int ll);
        max_lk_i = 16'(lk);
        max_ll_i = 16'(ll);
        for (int k = 0; k < lk; k++) begin
            for (int l = 0; l < ll; l++) begin
                exp_q.push_back({16'(k), 16'(l)});
            end
        end
        start_i   = 1'b1;
        start_cyc = cyc;
        tick();
        start_i = 1'b0;
    endtask

    task automatic runUntilDone(input int budget, input string tag);
        int d0;
        int n;
        d0 = done_seen;
        n  = 0;
        while (done_seen == d0 && n < budget) begin
            tick();
            n++;
        end
        if (done_seen == d0) checkOutput({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int i0;
        int d0;
        int s0;
        int n;
        rst_i = 1'b1; start_i = 1'b0; clear_i = 1'b0;
        max_lk_i = '0; max_ll_i = '0;
        ap_ready_i = 1'b0; ap_done_i = 1'b0; ap_idle_i = 1'b1; inj_done = 1'b0;
        model_en = 1'b0; pipe_mode = 1'b0; lat = 4;
        cyc = 0; issue_cnt = 0; start_seen = 0; done_seen = 0;
        done_cyc = -1; last_done_cyc = -1; start_cyc = 0;
        total_cnt = 0; bad_cnt = 0;

        #1;
        checkOutput("rst_ap_start", 32'(ap_start_o), 0);
        checkOutput("rst_idx", {idx_k_o, idx_l_o}, 0);
        checkOutput("rst_busy", 32'(busy_o), 0);
        checkOutput("rst_done", 32'(done_o), 0);
        checkOutput("rst_err", 32'(err_o), 0);
        checkOutput("rst_idle", 32'(idle_o), 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        @(posedge clk);
        #1;

        // sequential: HLS accepts only when it has nothing in flight
        $display("[TB] sequential 2x3");
        model_en = 1'b1; pipe_mode = 1'b0; lat = 4;
        i0 = issue_cnt; d0 = done_seen;
        applyStimulus(2, 3);
        runUntilDone(300, "seq");
        checkOutput("seq_done_lat", done_cyc, last_done_cyc + 1);
        repeat (3) tick();
        checkOutput("seq_issues", issue_cnt - i0, 6);
        checkOutput("seq_done_cnt", done_seen - d0, 1);
        checkOutput("seq_sb_empty", exp_q.size(), 0);
        checkOutput("seq_err", 32'(err_o), 0);

        // pipelined: HLS ready every cycle, limited by the outstanding bound
        $display("[TB] pipelined 1x8");
        pipe_mode = 1'b1; lat = 5;
        i0 = issue_cnt; d0 = done_seen;
        applyStimulus(1, 8);
        runUntilDone(300, "pipe");
        checkOutput("pipe_done_lat", done_cyc, last_done_cyc + 1);
        repeat (3) tick();
        checkOutput("pipe_issues", issue_cnt - i0, 8);
        checkOutput("pipe_done_cnt", done_seen - d0, 1);
        checkOutput("pipe_sb_empty", exp_q.size(), 0);
        checkOutput("pipe_err", 32'(err_o), 0);

        // zero outer bound: straight to completion
        $display("[TB] zero bound");
        s0 = start_seen; d0 = done_seen;
        applyStimulus(0, 5);
        repeat (3) tick();
        checkOutput("zero_ap_start", start_seen - s0, 0);
        checkOutput("zero_done_cnt", done_seen - d0, 1);
        checkOutput("zero_done_lat", done_cyc, start_cyc + 1);

        // clear after the third issue of a 4x4 run
        $display("[TB] mid-run clear");
        lat = 2; pipe_mode = 1'b1;
        i0 = issue_cnt; d0 = done_seen;
        applyStimulus(4, 4);
        n = 0;
        while (issue_cnt - i0 < 3 && n < 50) begin
            tick();
            n++;
        end
        if (issue_cnt - i0 < 3) checkOutput("clr_reach_timeout", 0, 1);
        clear_i = 1'b1; model_en = 1'b0;
        tick();
        clear_i = 1'b0;
        pend.delete();
        exp_q.delete();
        checkOutput("clr_ap_start", 32'(ap_start_o), 0);
        checkOutput("clr_idx", {idx_k_o, idx_l_o}, 0);
        checkOutput("clr_busy", 32'(busy_o), 0);
        repeat (4) tick();
        checkOutput("clr_no_done", done_seen - d0, 0);
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        checkOutput("clr_late_err", 32'(err_o), 1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        checkOutput("clr_err_cleared", 32'(err_o), 0);
        model_en = 1'b1;
        i0 = issue_cnt;
        applyStimulus(1, 1);
        runUntilDone(50, "clr_1x1");
        repeat (2) tick();
        checkOutput("clr_1x1_issues", issue_cnt - i0, 1);
        checkOutput("clr_1x1_sb", exp_q.size(), 0);
        checkOutput("clr_1x1_err", 32'(err_o), 0);

        // stray ap_done in IDLE, then a start while busy that must be ignored
        $display("[TB] protocol error and ignored start");
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        checkOutput("perr_set", 32'(err_o), 1);
        repeat (3) tick();
        checkOutput("perr_sticky", 32'(err_o), 1);
        pipe_mode = 1'b0; lat = 3;
        i0 = issue_cnt;
        applyStimulus(2, 2);
        tick();
        tick();
        max_lk_i = 16'd7; max_ll_i = 16'd7; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        runUntilDone(300, "ign");
        repeat (2) tick();
        checkOutput("ign_issues", issue_cnt - i0, 4);
        checkOutput("ign_sb_empty", exp_q.size(), 0);
        checkOutput("ign_err_sticky", 32'(err_o), 1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        checkOutput("perr_cleared", 32'(err_o), 0);

        // asynchronous reset in the middle of ISSUE
        $display("[TB] reset mid-operation");
        pipe_mode = 1'b1; lat = 4;
        i0 = issue_cnt;
        applyStimulus(3, 3);
        n = 0;
        while (issue_cnt - i0 < 2 && n < 50) begin
            tick();
            n++;
        end
        checkOutput("arst_pre_busy", 32'(busy_o), 1);
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput("arst_ap_start", 32'(ap_start_o), 0);
        checkOutput("arst_idx", {idx_k_o, idx_l_o}, 0);
        checkOutput("arst_busy", 32'(busy_o), 0);
        checkOutput("arst_done", 32'(done_o), 0);
        checkOutput("arst_err", 32'(err_o), 0);
        model_en = 1'b0; pend.delete(); exp_q.delete(); ap_ready_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("arst_idle_hi", 32'(idle_o), 1);
        ap_idle_i = 1'b0;
        #1;
        checkOutput("arst_idle_lo", 32'(idle_o), 0);
        ap_idle_i = 1'b1;
        #1;

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
